// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand collector: default widths, FSM states
// and the operand-need decode used by both the RTL and its scoreboard.
package alu_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ISSUE
    } state_e;

    // bit0 = OPA required, bit1 = OPB required; single-operand commands differ by mode
    function automatic logic [1:0] op_need(input logic mode, input logic [31:0] cmd);
        logic [1:0] need;
        need = 2'b11;
        if (mode) begin
            if (cmd == 32'd4 || cmd == 32'd5)      need = 2'b01;
            else if (cmd == 32'd6 || cmd == 32'd7) need = 2'b10;
        end else begin
            if (cmd == 32'd6 || cmd == 32'd8)      need = 2'b01;
            else if (cmd == 32'd7 || cmd == 32'd9) need = 2'b10;
        end
        return need;
    endfunction

endpackage

// File: rtl/alu_timeout_ctr.sv
// Collection-age counter: clear, load-to-one, increment, all gated by the clock
// enable; flags terminal count when the age reaches TIMEOUT.
module alu_timeout_ctr #(
    parameter int TIMEOUT = 16,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (clr_i)       count_d = '0;
            else if (load_i) count_d = CW'(1);
            else if (inc_i)  count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign tc_o = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/alu_op_collector.sv
// Operand-collection front end: gathers OPA/OPB over possibly several cycles,
// times out with a one-cycle ERR pulse, and hands a complete op to the ALU.
module alu_op_collector
    import alu_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         RST_N,
    input  logic         CE,
    input  logic [W-1:0] OPA,
    input  logic [W-1:0] OPB,
    input  logic         Cin,
    input  logic         mode,
    input  logic [N-1:0] CMD,
    input  logic [1:0]   inp_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_opa,
    output logic [W-1:0] out_opb,
    output logic         out_cin,
    output logic         out_mode,
    output logic [N-1:0] out_cmd,
    output logic         ERR
);

    state_e       state_q, state_d;
    logic [1:0]   have_q, have_d;
    logic [1:0]   need_q, need_d;
    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic [N-1:0] cmd_q, cmd_d;
    logic         mode_q, mode_d;
    logic         cin_q, cin_d;
    logic         err_q, err_d;

    logic         ctrClr, ctrLoad, ctrInc, ctrTc;
    logic [1:0]   reqNeed;
    logic [1:0]   mergedHave;

    alu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk    (clk),
        .rst_n  (RST_N),
        .en_i   (CE),
        .clr_i  (ctrClr),
        .load_i (ctrLoad),
        .inc_i  (ctrInc),
        .tc_o   (ctrTc)
    );

    assign reqNeed    = op_need(mode, 32'(CMD));
    assign mergedHave = have_q | inp_valid;

    // ERR only changes on enabled edges, so a pulse stretches while CE is low
    always_comb begin
        state_d = state_q;
        have_d  = have_q;
        need_d  = need_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        err_d   = err_q;
        ctrClr  = 1'b0;
        ctrLoad = 1'b0;
        ctrInc  = 1'b0;
        if (CE) begin
            err_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (inp_valid != 2'b00) begin
                        cmd_d  = CMD;
                        mode_d = mode;
                        cin_d  = Cin;
                        need_d = reqNeed;
                        have_d = inp_valid;
                        opa_d  = inp_valid[0] ? OPA : '0;
                        opb_d  = inp_valid[1] ? OPB : '0;
                        if ((inp_valid & reqNeed) == reqNeed) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = COLLECT;
                            ctrLoad = 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (inp_valid[0] && !have_q[0]) opa_d = OPA;
                    if (inp_valid[1] && !have_q[1]) opb_d = OPB;
                    have_d = mergedHave;
                    // completion is checked before timeout so it wins on the same edge
                    if ((mergedHave & need_q) == need_q) begin
                        state_d = ISSUE;
                        ctrClr  = 1'b1;
                    end else if (ctrTc) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        ctrClr  = 1'b1;
                    end else begin
                        ctrInc = 1'b1;
                    end
                end
                ISSUE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            have_q  <= '0;
            need_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            have_q  <= have_d;
            need_q  <= need_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q != ISSUE);
    assign out_valid = (state_q == ISSUE);
    assign out_opa   = need_q[0] ? opa_q : '0;
    assign out_opb   = need_q[1] ? opb_q : '0;
    assign out_cin   = cin_q;
    assign out_mode  = mode_q;
    assign out_cmd   = cmd_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_alu_op_collector.sv
// Self-checking bench for alu_op_collector: a transaction-level reference model
// compared every cycle, plus directed vectors with hand-computed literals.
module tb_alu_op_collector;

    localparam int W       = 8;
    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         RST_N;
    logic         CE;
    logic [W-1:0] OPA, OPB;
    logic         Cin, mode;
    logic [N-1:0] CMD;
    logic [1:0]   inp_valid;
    logic         in_ready, out_valid, out_ready;
    logic [W-1:0] out_opa, out_opb;
    logic         out_cin, out_mode;
    logic [N-1:0] out_cmd;
    logic         ERR;

    int compared   = 0;
    int mismatched = 0;

    alu_op_collector #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .CE        (CE),
        .OPA       (OPA),
        .OPB       (OPB),
        .Cin       (Cin),
        .mode      (mode),
        .CMD       (CMD),
        .inp_valid (inp_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opa   (out_opa),
        .out_opb   (out_opb),
        .out_cin   (out_cin),
        .out_mode  (out_mode),
        .out_cmd   (out_cmd),
        .ERR       (ERR)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] needOf(input logic md, input logic [N-1:0] c);
        if (md) begin
            if (c == 4 || c == 5) return 2'b01;
            if (c == 6 || c == 7) return 2'b10;
        end else begin
            if (c == 6 || c == 8) return 2'b01;
            if (c == 7 || c == 9) return 2'b10;
        end
        return 2'b11;
    endfunction

    // Reference: a pending operation is either being gathered (with an age in
    // enabled cycles since its first operand) or waiting for the ALU to take it.
    logic         mGathering, mWaiting, mErr;
    int           mAge;
    logic [1:0]   mHave, mNeed;
    logic [W-1:0] mOpa, mOpb;
    logic [N-1:0] mCmd;
    logic         mMode, mCin;

    always @(posedge clk or negedge RST_N) begin : modelProc
        logic         g, w, e;
        int           age;
        logic [1:0]   have, need;
        logic [W-1:0] a, b;
        logic [N-1:0] c;
        logic         md, ci;
        if (!RST_N) begin
            mGathering <= 1'b0;
            mWaiting   <= 1'b0;
            mErr       <= 1'b0;
            mAge       <= 0;
            mHave      <= 2'b00;
            mNeed      <= 2'b00;
            mOpa       <= '0;
            mOpb       <= '0;
            mCmd       <= '0;
            mMode      <= 1'b0;
            mCin       <= 1'b0;
        end else if (CE) begin
            g = mGathering; w = mWaiting; e = 1'b0; age = mAge;
            have = mHave; need = mNeed; a = mOpa; b = mOpb;
            c = mCmd; md = mMode; ci = mCin;
            if (w) begin
                if (out_ready) w = 1'b0;
            end else if (g) begin
                if (inp_valid[0] && !have[0]) a = OPA;
                if (inp_valid[1] && !have[1]) b = OPB;
                have = have | inp_valid;
                age  = age + 1;
                if ((have & need) == need) begin
                    g = 1'b0; w = 1'b1;
                end else if (age == TIMEOUT) begin
                    g = 1'b0; e = 1'b1;
                end
            end else if (inp_valid != 2'b00) begin
                need = needOf(mode, CMD);
                c = CMD; md = mode; ci = Cin;
                a = OPA; b = OPB; have = inp_valid; age = 0;
                if ((have & need) == need) w = 1'b1;
                else g = 1'b1;
            end
            mGathering <= g; mWaiting <= w; mErr <= e; mAge <= age;
            mHave <= have; mNeed <= need; mOpa <= a; mOpb <= b;
            mCmd <= c; mMode <= md; mCin <= ci;
        end
    end

    always @(negedge clk) begin
        checkOutput("out_valid", 32'(out_valid), 32'(mWaiting));
        checkOutput("in_ready", 32'(in_ready), 32'(!mWaiting));
        checkOutput("ERR", 32'(ERR), 32'(mErr));
        if (mWaiting) begin
            checkOutput("out_opa", 32'(out_opa), mNeed[0] ? 32'(mOpa) : 32'd0);
            checkOutput("out_opb", 32'(out_opb), mNeed[1] ? 32'(mOpb) : 32'd0);
            checkOutput("out_cmd", 32'(out_cmd), 32'(mCmd));
            checkOutput("out_mode", 32'(out_mode), 32'(mMode));
            checkOutput("out_cin", 32'(out_cin), 32'(mCin));
        end
    end

    task automatic applyStimulus(input logic ce, input logic [1:0] iv,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [N-1:0] c, input logic md,
                                 input logic ci, input logic ordy);
        CE = ce; inp_valid = iv; OPA = a; OPB = b;
        CMD = c; mode = md; Cin = ci; out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle(input logic ce, input logic ordy);
        applyStimulus(ce, 2'b00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, ordy);
    endtask

    initial begin
        RST_N = 1'b0; CE = 1'b1; inp_valid = 2'b00; OPA = '0; OPB = '0;
        CMD = '0; mode = 1'b0; Cin = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset ERR", 32'(ERR), 32'd0);
        checkOutput("reset out_opa", 32'(out_opa), 32'd0);
        checkOutput("reset out_cmd", 32'(out_cmd), 32'd0);
        RST_N = 1'b1;
        idleCycle(1'b1, 1'b1);

        // both operands together: issue straight away, then handshake back to idle
        applyStimulus(1'b1, 2'b11, 8'h12, 8'h34, 4'd0, 1'b1, 1'b1, 1'b1);
        checkOutput("full out_valid", 32'(out_valid), 32'd1);
        checkOutput("full out_opa", 32'(out_opa), 32'h12);
        checkOutput("full out_opb", 32'(out_opb), 32'h34);
        checkOutput("full out_cin", 32'(out_cin), 32'd1);
        checkOutput("model opa pin", 32'(mOpa), 32'h12);
        idleCycle(1'b1, 1'b1);
        checkOutput("full back idle", 32'(in_ready), 32'd1);

        // split operands three cycles apart
        applyStimulus(1'b1, 2'b01, 8'h05, 8'hEE, 4'd0, 1'b1, 1'b0, 1'b1);
        idleCycle(1'b1, 1'b1);
        idleCycle(1'b1, 1'b1);
        checkOutput("split waiting", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 2'b10, 8'hDD, 8'h07, 4'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("split out_valid", 32'(out_valid), 32'd1);
        checkOutput("split out_opa", 32'(out_opa), 32'h05);
        checkOutput("split out_opb", 32'(out_opb), 32'h07);
        checkOutput("split ERR", 32'(ERR), 32'd0);
        idleCycle(1'b1, 1'b1);

        // timeout after exactly TIMEOUT enabled edges
        applyStimulus(1'b1, 2'b01, 8'h01, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            idleCycle(1'b1, 1'b1);
            if (i == TIMEOUT - 1) checkOutput("timeout early ERR", 32'(ERR), 32'd0);
        end
        checkOutput("timeout ERR", 32'(ERR), 32'd1);
        checkOutput("timeout in_ready", 32'(in_ready), 32'd1);
        checkOutput("model ERR pin", 32'(mErr), 32'd1);
        idleCycle(1'b1, 1'b1);
        checkOutput("timeout ERR one cycle", 32'(ERR), 32'd0);

        // single-operand logical op with back-pressure
        applyStimulus(1'b1, 2'b01, 8'hAA, 8'h55, 4'd6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b11, 8'hFF, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);
            checkOutput("bp out_opa", 32'(out_opa), 32'hAA);
            checkOutput("bp out_opb", 32'(out_opb), 32'h00);
            checkOutput("bp in_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("bp out_cmd", 32'(out_cmd), 32'd6);
        idleCycle(1'b1, 1'b1);
        checkOutput("bp released", 32'(out_valid), 32'd0);

        // CE low for 4 cycles shifts the timeout; ERR stretches while CE low
        applyStimulus(1'b1, 2'b01, 8'h11, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idleCycle(1'b0, 1'b1);
        for (int i = 1; i <= TIMEOUT - 3; i++) begin
            idleCycle(1'b1, 1'b1);
            if (i == TIMEOUT - 4) checkOutput("ce shifted no ERR", 32'(ERR), 32'd0);
        end
        checkOutput("ce shifted ERR", 32'(ERR), 32'd1);
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b0, 1'b1);
        checkOutput("ERR stretched", 32'(ERR), 32'd1);
        idleCycle(1'b1, 1'b1);
        checkOutput("ERR cleared", 32'(ERR), 32'd0);

        // completion on the same edge as the timeout: completion wins
        applyStimulus(1'b1, 2'b01, 8'h3C, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) idleCycle(1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 8'h00, 8'hC3, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("edge out_valid", 32'(out_valid), 32'd1);
        checkOutput("edge ERR", 32'(ERR), 32'd0);
        checkOutput("edge out_opb", 32'(out_opb), 32'hC3);
        idleCycle(1'b1, 1'b1);

        // held operand not overwritten; command inputs ignored while collecting
        applyStimulus(1'b1, 2'b01, 8'h11, 8'h00, 4'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b01, 8'h99, 8'h00, 4'd4, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b10, 8'h77, 8'h22, 4'd4, 1'b0, 1'b1, 1'b1);
        checkOutput("hold out_opa", 32'(out_opa), 32'h11);
        checkOutput("hold out_opb", 32'(out_opb), 32'h22);
        checkOutput("hold out_cmd", 32'(out_cmd), 32'd2);
        checkOutput("hold out_mode", 32'(out_mode), 32'd1);
        idleCycle(1'b1, 1'b1);

        // OPB-only arrival for an OPA-only arithmetic command, then OPA completes
        applyStimulus(1'b1, 2'b10, 8'h00, 8'h44, 4'd4, 1'b1, 1'b0, 1'b1);
        checkOutput("need01 collecting", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 2'b01, 8'h5A, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("need01 out_opa", 32'(out_opa), 32'h5A);
        checkOutput("need01 out_opb", 32'(out_opb), 32'h00);
        idleCycle(1'b1, 1'b1);

        // asynchronous reset in the middle of an issue
        applyStimulus(1'b1, 2'b11, 8'h01, 8'h02, 4'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
        RST_N = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async in_ready", 32'(in_ready), 32'd1);
        checkOutput("async out_opa", 32'(out_opa), 32'd0);
        @(posedge clk); #2;
        RST_N = 1'b1;

        // reset in the middle of collection drops the op without any ERR
        applyStimulus(1'b1, 2'b01, 8'h66, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
        RST_N = 1'b0;
        @(posedge clk); #2;
        RST_N = 1'b1;
        for (int i = 0; i < TIMEOUT + 2; i++) idleCycle(1'b1, 1'b1);
        checkOutput("reset-collect ERR", 32'(ERR), 32'd0);
        checkOutput("reset-collect valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_op_collector.md
# alu_op_collector

Parametrised operand-collection front end that sits between the stimulus/driver side and the ALU core. Gathers OPA/OPB that may arrive on different cycles (per `inp_valid`), enforces a programmable collection timeout with `ERR`, and presents one complete operation to the ALU through a valid/ready handshake. It generalises the fixed 16-cycle operand-wait behaviour into a configurable, back-pressurable block.

## Interface
- `W`, 8, operand width
- `N`, 4, command width
- `TIMEOUT`, 16, max collection cycles (CE-qualified) before error; legal 2..255
- `clk`  in  1  clock, all state on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `CE`  in  1  clock enable; when 0 no state, counter or handshake advances
- `OPA`, `OPB`  in  W  operands
- `Cin`, `mode`  in  1  carry-in; mode (1 arithmetic, 0 logical)
- `CMD`  in  N  command
- `inp_valid`  in  2  bit0 = OPA valid, bit1 = OPB valid
- `in_ready`  out  1  block accepts a new operation / missing operand
- `out_valid`  out  1  complete operation presented
- `out_ready`  in  1  ALU accepts operation
- `out_opa`, `out_opb`  out  W  collected operands
- `out_cin`, `out_mode`  out  1  latched carry/mode
- `out_cmd`  out  N  latched command
- `ERR`  out  1  one-cycle timeout pulse

## Operation
- Need mask `need[1:0]` from (mode, CMD): mode=1: CMD 4,5 → 01; 6,7 → 10; else 11. mode=0: CMD 6,8 → 01; 7,9 → 10; else 11.
- States: IDLE, COLLECT, ISSUE. All transitions qualified by CE=1.
- IDLE (in_ready=1): on `inp_valid != 00`, latch CMD/mode/Cin, compute `need`, latch each supplied operand, `have = inp_valid`. If `(have & need) == need` → ISSUE; else → COLLECT, counter=1.
- COLLECT (in_ready=1): operands supplied by `inp_valid` are latched if still missing (already-held operand not overwritten); CMD/mode/Cin inputs ignored. Complete → ISSUE. Incomplete and counter == TIMEOUT → IDLE with ERR=1 next cycle, operation dropped. Else counter++.
- ISSUE (in_ready=0): out_valid=1, payload stable. On `out_valid && out_ready && CE` → IDLE. inputs ignored.
- Unneeded operand outputs are 0 (e.g. need=01 → out_opb=0).
- `inp_valid=00` in IDLE: no action; in COLLECT: counts toward timeout.

## Timing
- Reset (RST_N=0, async): state IDLE, counter 0, all out_* 0, out_valid 0, ERR 0, in_ready 1.
- `in_ready` decoded from state (registered state, no combinational path from inputs).
- Complete op accepted at edge k → out_valid=1 after edge k; min throughput one op per 2 cycles (no IDLE bypass on handshake).
- Split operands: second operand at edge k → out_valid after edge k.
- Timeout: first operand at edge k0; no completion through edge k0+TIMEOUT → ERR high for the cycle after edge k0+TIMEOUT, in IDLE, new op accepted from next edge.
- Completion and timeout on same edge: completion wins, no ERR.
- CE=0: everything frozen including ERR (pulse stretches until next CE edge), out_ready ignored.
- RST_N asserted mid-COLLECT/ISSUE: operation discarded, no ERR.

## Structure
- Package `alu_pkg`: default W/N, `state_e` enum (IDLE, COLLECT, ISSUE), function `op_need(mode, cmd)` returning need mask; shared with scoreboard.
- Sub-module `alu_timeout_ctr` (clear, enable, terminal-count at TIMEOUT, width $clog2(TIMEOUT+1)).
- Top holds FSM and operand/command registers.

## Test plan
- mode=1, CMD=0, OPA=8'h12, OPB=8'h34, inp_valid=11, out_ready=1 → next cycle out_valid=1, out_opa=12, out_opb=34, then IDLE.
- mode=1, CMD=0: cycle 0 inp_valid=01 OPA=05, cycle 3 inp_valid=10 OPB=07 → out_valid after cycle-3 edge, out_opa=05, out_opb=07, ERR=0.
- mode=1, CMD=0, inp_valid=01 then 00 for 16 cycles, TIMEOUT=16 → ERR=1 exactly one cycle, out_valid never 1, in_ready stays 1.
- mode=0, CMD=6, inp_valid=01 OPA=AA → issue immediately, out_opb=00; hold out_ready=0 for 5 cycles → payload stable, in_ready=0, new inputs ignored.
- CE=0 for 4 cycles mid-COLLECT → counter frozen, timeout shifted by 4; RST_N pulse mid-ISSUE → out_valid=0 immediately (async), no ERR.
